// File: rtl/pipe_hazard_ctrl.sv
// ID/EX sequencing controller: load-use bubble, multi-cycle MUL hold, taken-branch squash.
// Optional stall/flush counters are compiled in with `define HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rn,
    input  logic [4:0] ifid_rm,
    input  logic       ifid_uses_rm,
    input  logic       ex_mul_issue,
    input  logic       mem_branch_taken,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_write,
    output logic       idex_bubble,
    output logic       exmem_bubble,
    output logic       ifid_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] loaduse_stalls_o,
    output logic [31:0] mul_stall_cycles_o,
    output logic [31:0] flushes_o,
`endif
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {RUN = 2'd0, MUL_WAIT = 2'd1, FLUSH = 2'd2} state_t;

    state_t             state;
    logic [CNT_W-1:0]   mul_cnt;
    logic               load_use;

    // XZR reads as zero, so a load targeting X31 never feeds anything.
    assign load_use = idex_mem_read && (idex_rd != 5'd31) &&
                      ((idex_rd == ifid_rn) || (ifid_uses_rm && (idex_rd == ifid_rm)));

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        ifid_flush   = 1'b0;
        state_o      = state;
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            ifid_flush   = 1'b1;
            state_o      = 2'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_branch_taken) begin
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                        exmem_bubble = 1'b1;
                    end else if (ex_mul_issue) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                MUL_WAIT: begin
                    if (mem_branch_taken) begin
                        ifid_flush   = 1'b1;
                        idex_bubble  = 1'b1;
                        exmem_bubble = 1'b1;
                    end else if (mul_cnt != '0) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_write   = 1'b0;
                        exmem_bubble = 1'b1;
                    end
                end
                FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The hold that takes mul_cnt from 1 to 0 is the last one: the FSM is back in
    // RUN on the next cycle, so MUL_LATENCY-1 hold cycles including the issue cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            mul_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_branch_taken) begin
                        state <= FLUSH;
                    end else if (ex_mul_issue) begin
                        mul_cnt <= CNT_W'(MUL_LATENCY - 2);
                        state   <= MUL_WAIT;
                    end
                end
                MUL_WAIT: begin
                    if (mem_branch_taken) begin
                        mul_cnt <= '0;
                        state   <= FLUSH;
                    end else if (mul_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        mul_cnt <= mul_cnt - 1'b1;
                        if (mul_cnt == CNT_W'(1))
                            state <= RUN;
                    end
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic lu_evt, mul_evt, flush_evt;

    assign lu_evt    = (state == RUN) && !mem_branch_taken && !ex_mul_issue && load_use;
    assign mul_evt   = ((state == RUN) && !mem_branch_taken && ex_mul_issue) ||
                       ((state == MUL_WAIT) && !pc_write);
    assign flush_evt = (state == RUN) && mem_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaduse_stalls_o   <= '0;
            mul_stall_cycles_o <= '0;
            flushes_o          <= '0;
        end else begin
            if (lu_evt && (loaduse_stalls_o != '1))
                loaduse_stalls_o <= loaduse_stalls_o + 32'd1;
            if (mul_evt && (mul_stall_cycles_o != '1))
                mul_stall_cycles_o <= mul_stall_cycles_o + 32'd1;
            if (flush_evt && (flushes_o != '1))
                flushes_o <= flushes_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (MUL_LATENCY=4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       idex_mem_read = 1'b0;
    logic [4:0] idex_rd = 5'd0;
    logic [4:0] ifid_rn = 5'd0;
    logic [4:0] ifid_rm = 5'd0;
    logic       ifid_uses_rm = 1'b0;
    logic       ex_mul_issue = 1'b0;
    logic       mem_branch_taken = 1'b0;
    logic       pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] loaduse_stalls_o, mul_stall_cycles_o, flushes_o;
`endif

    int errs = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
        .ex_mul_issue(ex_mul_issue), .mem_branch_taken(mem_branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble), .ifid_flush(ifid_flush),
`ifdef HAZARD_PERF_CNT_EN
        .loaduse_stalls_o(loaduse_stalls_o), .mul_stall_cycles_o(mul_stall_cycles_o),
        .flushes_o(flushes_o),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, state_o}
    localparam logic [7:0] DEF   = 8'b111000_00;
    localparam logic [7:0] LU    = 8'b001100_00;
    localparam logic [7:0] BR_R  = 8'b111111_00;
    localparam logic [7:0] BR_M  = 8'b111111_01;
    localparam logic [7:0] MUL_R = 8'b000010_00;
    localparam logic [7:0] MUL_M = 8'b000010_01;
    localparam logic [7:0] FLS   = 8'b111101_10;
    localparam logic [7:0] RST   = 8'b000111_00;

    logic [7:0] outs;
    assign outs = {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble, ifid_flush, state_o};

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic drv(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic um, input logic mul, input logic br);
        idex_mem_read = mr; idex_rd = rd; ifid_rn = rn; ifid_rm = rm;
        ifid_uses_rm = um; ex_mul_issue = mul; mem_branch_taken = br;
    endtask

    // Check at the falling edge, then advance to just past the next rising edge.
    task automatic vec(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(negedge clk);
        chk("reset_hold", outs, RST);
        @(posedge clk); #1;
        rst_n = 1'b1;

        drv(0, 0, 0, 0, 0, 0, 0);  vec("idle", DEF);
        drv(1, 5, 5, 0, 0, 0, 0);  vec("lu_rn", LU);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("lu_rn_after", DEF);
        drv(1, 9, 0, 9, 1, 0, 0);  vec("lu_rm", LU);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("lu_rm_after", DEF);
        drv(1, 31, 31, 31, 1, 0, 0); vec("xzr", DEF);
        drv(1, 7, 0, 7, 0, 0, 0);  vec("rm_unused", DEF);

        drv(0, 0, 0, 0, 0, 1, 0);  vec("mul_issue", MUL_R);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("mul_w1", MUL_M);
        vec("mul_w2", MUL_M);
        vec("mul_done", DEF);

        drv(0, 0, 0, 0, 0, 0, 1);  vec("br_run", BR_R);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("br_flush", FLS);
        vec("br_after", DEF);

        drv(0, 0, 0, 0, 0, 1, 0);  vec("mulbr_issue", MUL_R);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("mulbr_w1", MUL_M);
        drv(0, 0, 0, 0, 0, 0, 1);  vec("mulbr_br", BR_M);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("mulbr_flush", FLS);
        vec("mulbr_after", DEF);

        drv(1, 5, 5, 0, 0, 0, 1);  vec("br_lu", BR_R);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("br_lu_flush", FLS);
        vec("br_lu_after", DEF);

        drv(0, 0, 0, 0, 0, 0, 1);  vec("br_twice", BR_R);
        vec("br_in_flush", FLS);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("br_twice_after", DEF);

        drv(1, 5, 5, 0, 0, 1, 0);  vec("mul_lu_issue", MUL_R);
        drv(1, 5, 5, 0, 0, 0, 0);  vec("mul_lu_w1", MUL_M);
        vec("mul_lu_w2", MUL_M);
        vec("mul_lu_reeval", LU);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("mul_lu_after", DEF);

        drv(0, 0, 0, 0, 0, 1, 0);  vec("rst_mul_issue", MUL_R);
        drv(0, 0, 0, 0, 0, 0, 0);  vec("rst_mul_w1", MUL_M);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", outs, RST);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vec("post_rst1", DEF);
        vec("post_rst2", DEF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
